// File: rtl/restoring_divider_if.sv
// Handshake and result bundle shared between the divider and whatever drives it.
// The master drives the operands and Run; the slave (the divider) returns results and status.
interface restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             Run;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Run, Dividend, Divisor,
    input  Quotient, Remainder, Busy, Done, DivByZero
  );

  modport slave (
    input  Run, Dividend, Divisor,
    output Quotient, Remainder, Busy, Done, DivByZero
  );
endinterface

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock via a WIDTH+1-bit
// trial subtraction. Results are registered and held until the next completion or reset.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  restoring_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   s, t, r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last;
  logic             start;

  // The top bit of the difference is the borrow: set means the divisor did not fit.
  function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0] a,
                                               input logic [WIDTH-1:0] b);
    return a - {1'b0, b};
  endfunction

  always_comb begin
    s     = (r << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
    t     = trial_sub(s, d);
    r_nxt = t[WIDTH] ? s : t;
    q_nxt = {q[WIDTH-2:0], ~t[WIDTH]};
    last  = (cnt == CW'(WIDTH - 1));
    start = (state == IDLE) && bus.Run;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (!bus.Run)                 state_nxt = IDLE;
        else if (bus.Divisor == '0)   state_nxt = DONE;
        else                          state_nxt = CALC;
      end
      CALC:    state_nxt = last ? DONE : CALC;
      DONE:    state_nxt = bus.Run ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.Busy = 1'b0;
    bus.Done = 1'b0;
    case (state)
      CALC:    bus.Busy = 1'b1;
      DONE:    bus.Done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on start, iterate in CALC, publish results only on completion.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r             <= '0;
      q             <= '0;
      d             <= '0;
      cnt           <= '0;
      bus.Quotient  <= '0;
      bus.Remainder <= '0;
      bus.DivByZero <= 1'b0;
    end else if (start) begin
      r   <= '0;
      q   <= bus.Dividend;
      d   <= bus.Divisor;
      cnt <= '0;
      if (bus.Divisor == '0) begin
        bus.Quotient  <= '1;
        bus.Remainder <= bus.Dividend;
        bus.DivByZero <= 1'b1;
      end
    end else if (state == CALC) begin
      r   <= r_nxt;
      q   <= q_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        bus.Quotient  <= q_nxt;
        bus.Remainder <= r_nxt[WIDTH-1:0];
        bus.DivByZero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and randomized checks of restoring_divider: result values, latency, Busy width,
// divide-by-zero handling, Run held high, operand changes mid-run and asynchronous reset.
module tb_restoring_divider;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  restoring_divider_if #(.WIDTH(W)) bus ();

  restoring_divider #(.WIDTH(W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Starts a division and waits (bounded) for Done, then releases Run and lets the FSM return to IDLE.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                        output int lat, output int busy_n);
    @(negedge clk);
    bus.Dividend = a;
    bus.Divisor  = b;
    bus.Run      = 1'b1;
    lat    = 0;
    busy_n = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (bus.Busy) busy_n++;
    end while (!bus.Done && lat < 40);
    q = bus.Quotient;
    r = bus.Remainder;
    z = bus.DivByZero;
    bus.Run = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t         vecs[10];
  logic [W-1:0] gq, gr;
  logic         gz;
  int           lat, busy_n;

  initial begin
    vecs[0] = '{dvd: 8'd100, dvs: 8'd7,   q: 8'd14,  r: 8'd2,   dbz: 1'b0};
    vecs[1] = '{dvd: 8'd255, dvs: 8'd1,   q: 8'd255, r: 8'd0,   dbz: 1'b0};
    vecs[2] = '{dvd: 8'd255, dvs: 8'd255, q: 8'd1,   r: 8'd0,   dbz: 1'b0};
    vecs[3] = '{dvd: 8'd5,   dvs: 8'd9,   q: 8'd0,   r: 8'd5,   dbz: 1'b0};
    vecs[4] = '{dvd: 8'd0,   dvs: 8'd3,   q: 8'd0,   r: 8'd0,   dbz: 1'b0};
    vecs[5] = '{dvd: 8'd37,  dvs: 8'd0,   q: 8'hFF,  r: 8'd37,  dbz: 1'b1};
    vecs[6] = '{dvd: 8'd200, dvs: 8'd16,  q: 8'd12,  r: 8'd8,   dbz: 1'b0};
    vecs[7] = '{dvd: 8'd9,   dvs: 8'd2,   q: 8'd4,   r: 8'd1,   dbz: 1'b0};
    vecs[8] = '{dvd: 8'd254, dvs: 8'd255, q: 8'd0,   r: 8'd254, dbz: 1'b0};
    vecs[9] = '{dvd: 8'd128, dvs: 8'd3,   q: 8'd42,  r: 8'd2,   dbz: 1'b0};

    bus.Run      = 1'b0;
    bus.Dividend = '0;
    bus.Divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q",    int'(bus.Quotient),  0);
    chk("rst_r",    int'(bus.Remainder), 0);
    chk("rst_busy", int'(bus.Busy),      0);
    chk("rst_done", int'(bus.Done),      0);
    chk("rst_dbz",  int'(bus.DivByZero), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_div(vecs[i].dvd, vecs[i].dvs, gq, gr, gz, lat, busy_n);
      chk($sformatf("v%0d_q", i),    int'(gq), int'(vecs[i].q));
      chk($sformatf("v%0d_r", i),    int'(gr), int'(vecs[i].r));
      chk($sformatf("v%0d_dbz", i),  int'(gz), int'(vecs[i].dbz));
      chk($sformatf("v%0d_lat", i),  lat,      vecs[i].dbz ? 1 : W + 1);
      chk($sformatf("v%0d_busy", i), busy_n,   vecs[i].dbz ? 0 : W);
      chk($sformatf("v%0d_idle_done", i), int'(bus.Done), 0);
      chk($sformatf("v%0d_hold_q", i),    int'(bus.Quotient),  int'(vecs[i].q));
      chk($sformatf("v%0d_hold_r", i),    int'(bus.Remainder), int'(vecs[i].r));
    end

    // Run held for many cycles with the dividend changed mid-calculation: one run only.
    @(negedge clk);
    bus.Dividend = 8'd100;
    bus.Divisor  = 8'd7;
    bus.Run      = 1'b1;
    busy_n = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus.Busy) busy_n++;
      if (c == 3) bus.Dividend = 8'd50;
    end
    chk("held_busy", busy_n,                 W);
    chk("held_done", int'(bus.Done),         1);
    chk("held_q",    int'(bus.Quotient),     14);
    chk("held_r",    int'(bus.Remainder),    2);
    bus.Run = 1'b0;
    @(posedge clk); #1;
    chk("held_release", int'(bus.Done), 0);

    // Leave DivByZero set, then reset in the middle of a normal division.
    do_div(8'd37, 8'd0, gq, gr, gz, lat, busy_n);
    chk("pre_rst_dbz", int'(gz), 1);
    @(negedge clk);
    bus.Dividend = 8'd200;
    bus.Divisor  = 8'd16;
    bus.Run      = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_busy_before", int'(bus.Busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_q",    int'(bus.Quotient),  0);
    chk("mid_rst_r",    int'(bus.Remainder), 0);
    chk("mid_rst_busy", int'(bus.Busy),      0);
    chk("mid_rst_done", int'(bus.Done),      0);
    chk("mid_rst_dbz",  int'(bus.DivByZero), 0);
    bus.Run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_div(8'd9, 8'd2, gq, gr, gz, lat, busy_n);
    chk("post_rst_q",   int'(gq), 4);
    chk("post_rst_r",   int'(gr), 1);
    chk("post_rst_lat", lat,      W + 1);

    // Randomized sweep against a behavioural reference, with the operand extremes forced in.
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] a, b, eq, er;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      if (n == 0) begin a = 8'd0;   b = 8'd255; end
      if (n == 1) begin a = 8'd255; b = 8'd0;   end
      if (n == 2) begin a = 8'd255; b = 8'd2;   end
      if (n == 3) begin a = 8'd0;   b = 8'd0;   end
      if (b == 0) begin
        eq = 8'hFF;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      do_div(a, b, gq, gr, gz, lat, busy_n);
      chk($sformatf("rnd%0d_q(%0d/%0d)", n, a, b), int'(gq), int'(eq));
      chk($sformatf("rnd%0d_r(%0d/%0d)", n, a, b), int'(gr), int'(er));
      if (b != 0)
        chk($sformatf("rnd%0d_inv", n),
            int'((int'(a) == int'(gq) * int'(b) + int'(gr)) && (gr < b)), 1);
      else
        chk($sformatf("rnd%0d_dbz", n), int'(gz), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
